// File: rtl/pe_seq.sv
// pe_seq: sequences LOAD/DOT commands onto a PE (cmd in, operand stream in, result out, pe_* drive pins, pe_out readback)
module pe_seq #(
  parameter int IN_PRECISION  = 16,
  parameter int OUT_PRECISION = 16,
  parameter int REG_SIZE      = 4,
  parameter int LEN_W         = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_op,
  input  logic [LEN_W-1:0]         cmd_len,
  input  logic                     cmd_reuse,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [IN_PRECISION-1:0]  s_act,
  input  logic [IN_PRECISION-1:0]  s_wgt,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [OUT_PRECISION-1:0] res_data,
  output logic [IN_PRECISION-1:0]  pe_act,
  output logic [IN_PRECISION-1:0]  pe_wgt,
  output logic                     pe_store,
  output logic                     pe_reuse,
  output logic                     pe_finish,
  output logic [REG_SIZE-1:0]      pe_addr,
  input  logic [OUT_PRECISION-1:0] pe_out
);
  typedef enum logic [2:0] {IDLE, LOAD, MAC, FIN, CAPT, RESP} state_t;
  state_t state, state_nx;
  logic reuse, beat, last, load_beat, mac_beat;
  logic [LEN_W-1:0] len, cnt;
  logic [REG_SIZE-1:0] ptr, ptr_inc;
  assign cmd_ready = state == IDLE;
  assign s_ready   = !rst && (state == LOAD || state == MAC);
  assign res_valid = !rst && state == RESP;
  assign beat      = s_valid && s_ready;
  assign last      = cnt == len - 1'b1;
  assign load_beat = beat && state == LOAD;
  assign mac_beat  = beat && state == MAC;
  assign ptr_inc   = ptr == REG_SIZE'(REG_SIZE - 1) ? REG_SIZE'(1) : ptr + 1'b1;
  assign pe_act    = mac_beat ? s_act : '0;
  assign pe_wgt    = load_beat || (mac_beat && !reuse) ? s_wgt : '0;
  assign pe_store  = load_beat;
  assign pe_reuse  = mac_beat && reuse;
  assign pe_addr   = load_beat || pe_reuse ? ptr : '0;
  assign pe_finish = !rst && state == FIN;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (cmd_valid) state_nx = cmd_op ? (cmd_len == '0 ? IDLE : LOAD) : (cmd_len == '0 ? FIN : MAC);
      LOAD: if (beat && last) state_nx = IDLE;
      MAC:  if (beat && last) state_nx = FIN;
      FIN:  state_nx = CAPT;
      CAPT: state_nx = RESP;
      RESP: if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= REG_SIZE'(1);
      cnt      <= '0;
      len      <= '0;
      reuse    <= 1'b0;
      res_data <= '0;
    end else begin
      state <= state_nx;
      if (cmd_valid && cmd_ready) begin
        len   <= cmd_len;
        reuse <= cmd_reuse;
        cnt   <= '0;
        ptr   <= REG_SIZE'(1);
      end
      if (beat) cnt <= cnt + 1'b1;
      if (load_beat || pe_reuse) ptr <= ptr_inc;
      if (state == CAPT) res_data <= pe_out;
    end
  end
endmodule

// File: doc/pe_seq.md
PE_SEQ -- requirements
Module: pe_seq

Interface
REQ-001 Parameter IN_PRECISION, default 16: act/wgt width.
REQ-002 Parameter OUT_PRECISION, default 16: PE result width, >= IN_PRECISION.
REQ-003 Parameter REG_SIZE, default 4: PE register-file depth and pe_addr width; reg 0 is the PE accumulator.
REQ-004 Parameter LEN_W, default 8: command length width.
REQ-005 clk  in  1  clock; all state updates on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 cmd_valid/cmd_ready  in/out  1/1  command handshake; transfer when both high.
REQ-008 cmd_op  in  1  0 = DOT (dot product), 1 = LOAD (store weights into PE regfile).
REQ-009 cmd_len  in  LEN_W  number of stream beats for the command.
REQ-010 cmd_reuse  in  1  DOT only: 1 = take weights from PE regfile, 0 = take s_wgt.
REQ-011 s_valid/s_ready  in/out  1/1  operand stream handshake; beat when both high.
REQ-012 s_act, s_wgt  in  IN_PRECISION each  operand beat.
REQ-013 res_valid/res_ready  out/in  1/1  result handshake.
REQ-014 res_data  out  OUT_PRECISION  dot-product result.
REQ-015 pe_act, pe_wgt  out  IN_PRECISION each; pe_store, pe_reuse, pe_finish  out  1 each; pe_addr  out  REG_SIZE: PE drive pins, combinational from state and stream.
REQ-016 pe_out  in  OUT_PRECISION  PE output register.

Function
REQ-017 FSM states IDLE, LOAD, MAC, FIN, CAPT, RESP; cmd_ready = 1 only in IDLE.
REQ-018 IDLE: on command transfer, latch op/len/reuse, clear beat counter, set weight pointer to 1; go to LOAD (op=1) or MAC (op=0); if cmd_len=0, LOAD returns to IDLE and MAC goes to FIN.
REQ-019 s_ready = 1 only in LOAD and MAC.
REQ-020 The PE accumulates every cycle, so pe_act SHALL be 0 in every cycle without a MAC beat (IDLE, LOAD, FIN, CAPT, RESP, and MAC with s_valid=0).
REQ-021 LOAD beat: pe_store=1, pe_wgt=s_wgt, pe_addr=pointer, pe_act=0, pe_reuse=0; then the pointer increments, wrapping from REG_SIZE-1 to 1 (address 0 is never written).
REQ-022 LOAD: after the cmd_len-th beat, return to IDLE.
REQ-023 MAC beat with reuse=0: pe_act=s_act, pe_wgt=s_wgt, pe_reuse=0, pe_addr=0.
REQ-024 MAC beat with reuse=1: pe_act=s_act, pe_reuse=1, pe_addr=pointer, pe_wgt=0, s_wgt ignored; then the pointer advances with the REQ-021 wrap.
REQ-025 MAC: after the cmd_len-th beat, go to FIN; pe_store=0 throughout.
REQ-026 FIN: exactly 1 cycle; pe_finish=1, pe_act=0.
REQ-027 CAPT: exactly 1 cycle; res_data <= pe_out at the end of the cycle.
REQ-028 RESP: res_valid=1, res_data stable until res_ready=1, then go to IDLE.
REQ-029 Minimum latency: res_valid first high 3 cycles after the cycle of the last MAC beat.
REQ-030 Arithmetic: no saturation; res_data equals the PE accumulator modulo 2^OUT_PRECISION.
REQ-031 The pointer persists across commands; each new command re-initializes it to 1.

Reset
REQ-032 rst SHALL force IDLE with cmd_ready=1, s_ready=0, res_valid=0, res_data=0, pointer=1, counter=0, and all pe_* outputs 0.
REQ-033 rst mid-command SHALL abandon the command with no result; the PE shares rst.

Verification
REQ-034 DOT len 3, reuse 0, act (1,2,3), wgt (4,5,6) -> one pe_finish pulse the cycle after beat 3; res_data=32, res_valid 3 cycles after beat 3.
REQ-035 LOAD len 3, wgt (2,3,4) -> pe_addr 1,2,3, pe_act 0; then DOT reuse len 3, act (1,1,1) -> pe_addr 1,2,3, res_data=9.
REQ-036 LOAD len 4, wgt (7,8,9,10) -> pe_addr 1,2,3,1; then DOT reuse len 3, act (1,0,0) -> res_data=10.
REQ-037 DOT case of REQ-034 with s_valid low 2 cycles between beats -> pe_act=0 in gap cycles, res_data=32.
REQ-038 res_ready low 5 cycles -> res_valid and res_data held, cmd_ready=0; accepted on 6th cycle, then IDLE.
REQ-039 rst after 2 beats of a DOT len 3, then DOT len 1 act 3 wgt 5 -> no earlier result; res_data=15; DOT len 0 -> res_data=0.
